// File: rtl/ld_field_sequencer_pkg.sv
// ld_field_sequencer_pkg
//   Shared definitions for the load-field sequencer: FSM state encoding,
//   default geometry (channel count, field width, MSB strip mask) and the
//   channel index constants of the RTC field layout.
package ld_field_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int N_CH_DEF = 9;
    localparam int W_DEF    = 8;
    localparam logic [8:0] MSB_MASK_DEF = 9'b000000100;

    localparam int CH_SEG    = 0;
    localparam int CH_MIN    = 1;
    localparam int CH_HORA   = 2;
    localparam int CH_DAY    = 3;
    localparam int CH_MONTH  = 4;
    localparam int CH_YEAR   = 5;
    localparam int CH_SEG_T  = 6;
    localparam int CH_MIN_T  = 7;
    localparam int CH_HORA_T = 8;

endpackage

// File: rtl/ld_field_sequencer_check.sv
// bcd_field_check
//   Combinational clean-up of one BCD field: optionally clears the top bit
//   (12/24 hour flag on hora), then flags any nibble above 9. A bad field is
//   replaced by all zeros so the downstream counter never loads garbage.
//   Ports:
//     raw       in  W  field value from the snapshot
//     strip_msb in  1  clear bit W-1 before checking
//     clean     out W  masked value, or zero when bad
//     bad       out 1  some nibble of the masked value exceeds 9
module bcd_field_check #(
    parameter int W = 8
) (
    input  logic [W-1:0] raw,
    input  logic         strip_msb,
    output logic [W-1:0] clean,
    output logic         bad
);

    logic [W-1:0] masked;

    always_comb begin
        masked = raw;
        if (strip_msb) begin
            masked[W-1] = 1'b0;
        end
        bad = 1'b0;
        for (int n = 0; n < W / 4; n++) begin
            if (masked[n*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        clean = bad ? '0 : masked;
    end

endmodule

// File: rtl/ld_field_sequencer.sv
// ld_field_sequencer
//   Snapshots N_CH packed BCD fields on an accepted start and streams them
//   (all channels, or one selected channel) to a downstream counter over a
//   valid/ready load port. Sticky err_bcd reports any sent field that held a
//   non-BCD nibble.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start, single       request; single selects one-channel mode
//     sel_ch              channel for single mode (out of range -> ch 0)
//     fields              packed input fields, channel i at [i*W +: W]
//     ld_ready            downstream accepts this cycle
//     ld_valid/addr/data  load port (registered)
//     busy, done, err_bcd status (registered)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; load port idle
//   SEND    | presenting snapshot[idx]; advance on ld_valid & ld_ready
//   DONE    | one-cycle done pulse, start ignored, then back to IDLE
module ld_field_sequencer
    import ld_field_sequencer_pkg::*;
#(
    parameter int              N_CH     = N_CH_DEF,
    parameter int              W        = W_DEF,
    parameter logic [N_CH-1:0] MSB_MASK = N_CH'(MSB_MASK_DEF),
    localparam int             CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            single,
    input  logic [CW-1:0]   sel_ch,
    input  logic [N_CH*W-1:0] fields,
    input  logic            ld_ready,
    output logic            ld_valid,
    output logic [CW-1:0]   ld_addr,
    output logic [W-1:0]    ld_data,
    output logic            busy,
    output logic            done,
    output logic            err_bcd
);

    localparam logic [CW:0]   N_CH_EXT = (CW + 1)'(N_CH);
    localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          single_q, single_d;
    logic [W-1:0]  snap_q [N_CH];
    logic [W-1:0]  snap_d [N_CH];
    logic          ld_valid_q, ld_valid_d;
    logic [CW-1:0] ld_addr_q, ld_addr_d;
    logic [W-1:0]  ld_data_q, ld_data_d;
    logic          ld_err_q, ld_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_bcd_q, err_bcd_d;
    logic          load_out;

    logic [W-1:0]  chk_clean;
    logic          chk_bad;

    // The checker looks at the entry that will be presented next cycle, so the
    // first field is already valid in the cycle right after start.
    bcd_field_check #(.W(W)) u_check (
        .raw       (snap_d[idx_d]),
        .strip_msb (MSB_MASK[idx_d]),
        .clean     (chk_clean),
        .bad       (chk_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            single_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) snap_q[i] <= '0;
            ld_valid_q <= 1'b0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
            ld_err_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_bcd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            single_q   <= single_d;
            for (int i = 0; i < N_CH; i++) snap_q[i] <= snap_d[i];
            ld_valid_q <= ld_valid_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
            ld_err_q   <= ld_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_bcd_q  <= err_bcd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        single_d   = single_q;
        for (int i = 0; i < N_CH; i++) snap_d[i] = snap_q[i];
        ld_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_bcd_d  = err_bcd_q;
        load_out   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_CH; i++) snap_d[i] = fields[i*W +: W];
                    single_d = single;
                    if (single && ({1'b0, sel_ch} < N_CH_EXT)) idx_d = sel_ch;
                    else                                       idx_d = '0;
                    err_bcd_d  = 1'b0;
                    ld_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    load_out   = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                ld_valid_d = 1'b1;
                if (ld_valid_q && ld_ready) begin
                    err_bcd_d = err_bcd_q | ld_err_q;
                    if (single_q || idx_q == LAST_CH) begin
                        ld_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        idx_d    = idx_q + CW'(1);
                        load_out = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        ld_err_d  = ld_err_q;
        if (load_out) begin
            ld_addr_d = idx_d;
            ld_data_d = chk_clean;
            ld_err_d  = chk_bad;
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_addr  = ld_addr_q;
    assign ld_data  = ld_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_bcd  = err_bcd_q;

endmodule

// File: tb/tb_ld_field_sequencer.sv
module tb_ld_field_sequencer;
    import ld_field_sequencer_pkg::*;

    localparam int N_CH = 9;
    localparam int W    = 8;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              single;
    logic [CW-1:0]     sel_ch;
    logic [N_CH*W-1:0] fields;
    logic              ld_ready;
    logic              ld_valid;
    logic [CW-1:0]     ld_addr;
    logic [W-1:0]      ld_data;
    logic              busy;
    logic              done;
    logic              err_bcd;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] raw_a [N_CH] = '{8'h59, 8'h45, 8'h92, 8'h31, 8'h12, 8'h16, 8'h30, 8'h10, 8'h05};
    logic [7:0] exp_a [N_CH] = '{8'h59, 8'h45, 8'h12, 8'h31, 8'h12, 8'h16, 8'h30, 8'h10, 8'h05};

    ld_field_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .single   (single),
        .sel_ch   (sel_ch),
        .fields   (fields),
        .ld_ready (ld_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy),
        .done     (done),
        .err_bcd  (err_bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fields(input logic [7:0] v [N_CH]);
        for (int i = 0; i < N_CH; i++) fields[i*W +: W] = v[i];
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, 32'(ld_valid), 0);
        chk({tag, "_addr"},  32'(ld_addr),  0);
        chk({tag, "_data"},  32'(ld_data),  0);
        chk({tag, "_busy"},  32'(busy),     0);
        chk({tag, "_done"},  32'(done),     0);
        chk({tag, "_err"},   32'(err_bcd),  0);
    endtask

    task automatic run_to_done(input string tag);
        int i;
        i = 0;
        while (!done && i < 30) begin
            step();
            i++;
        end
        chk({tag, "_done_reached"}, 32'(done), 1);
        step();
    endtask

    initial begin
        logic [7:0] v [N_CH];
        reset = 1'b1; start = 1'b0; single = 1'b0; sel_ch = '0;
        fields = '0; ld_ready = 1'b1;
        step(); step();
        chk_idle_zero("rst");
        reset = 1'b0;
        step();

        // Burst with ld_ready high: one field per cycle, hora MSB stripped.
        load_fields(raw_a);
        start = 1'b1; single = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            chk($sformatf("b1_valid%0d", k), 32'(ld_valid), 1);
            chk($sformatf("b1_addr%0d", k),  32'(ld_addr),  32'(k));
            chk($sformatf("b1_data%0d", k),  32'(ld_data),  32'(exp_a[k]));
            chk($sformatf("b1_busy%0d", k),  32'(busy),     1);
            step();
        end
        chk("b1_done",  32'(done),     1);
        chk("b1_valid", 32'(ld_valid), 0);
        chk("b1_busy",  32'(busy),     0);
        chk("b1_err",   32'(err_bcd),  0);
        step();
        chk("b1_done_clr", 32'(done), 0);

        // Single channel 4 with three stalled cycles.
        start = 1'b1; single = 1'b1; sel_ch = 4'd4;
        step();
        start = 1'b0; ld_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s4_valid%0d", k), 32'(ld_valid), 1);
            chk($sformatf("s4_addr%0d", k),  32'(ld_addr),  4);
            chk($sformatf("s4_data%0d", k),  32'(ld_data),  32'h12);
            step();
        end
        ld_ready = 1'b1;
        chk("s4_valid3", 32'(ld_valid), 1);
        chk("s4_data3",  32'(ld_data),  32'h12);
        step();
        chk("s4_done",  32'(done),     1);
        chk("s4_valid", 32'(ld_valid), 0);
        chk("s4_busy",  32'(busy),     0);
        step();
        chk("s4_after_valid", 32'(ld_valid), 0);

        // Non-BCD field on ch1: zeroed, err_bcd sticky until next start.
        v = raw_a; v[1] = 8'h3A;
        load_fields(v);
        start = 1'b1; single = 1'b0;
        step();
        start = 1'b0;
        chk("e_addr0", 32'(ld_addr), 0);
        chk("e_err0",  32'(err_bcd), 0);
        step();
        chk("e_addr1", 32'(ld_addr), 1);
        chk("e_data1", 32'(ld_data), 0);
        chk("e_err1",  32'(err_bcd), 0);
        step();
        chk("e_err2",  32'(err_bcd), 1);
        while (!done && ld_addr != 4'd0) step();
        chk("e_done",     32'(done),    1);
        chk("e_err_done", 32'(err_bcd), 1);
        step();
        chk("e_err_idle", 32'(err_bcd), 1);
        load_fields(raw_a);
        start = 1'b1; single = 1'b1; sel_ch = 4'd0;
        step();
        start = 1'b0;
        chk("e_err_clr", 32'(err_bcd), 0);
        run_to_done("e_single");

        // Snapshot coherence and start ignored while busy.
        load_fields(raw_a);
        start = 1'b1; single = 1'b0;
        step();
        fields[0 +: W] = 8'h00;
        chk("c_data0", 32'(ld_data), 32'h59);
        step();
        chk("c_data1", 32'(ld_data), 32'h45);
        for (int k = 0; k < 20 && !done; k++) step();
        chk("c_done", 32'(done), 1);
        start = 1'b0;
        step();
        chk("c_idle_valid", 32'(ld_valid), 0);
        chk("c_idle_busy",  32'(busy),     0);
        chk("c_idle_done",  32'(done),     0);
        step();
        chk("c_idle2_valid", 32'(ld_valid), 0);

        // Reset mid-burst at the third handshake.
        load_fields(raw_a);
        start = 1'b1; single = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("r_addr2_pre", 32'(ld_addr), 1);
        step();
        chk("r_addr2", 32'(ld_addr), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle_zero("r_after");
        step();
        chk("r_no_done",  32'(done),     0);
        chk("r_no_valid", 32'(ld_valid), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("r_restart_valid", 32'(ld_valid), 1);
        chk("r_restart_addr",  32'(ld_addr),  0);
        chk("r_restart_data",  32'(ld_data),  32'h59);
        run_to_done("r_restart");

        // Out-of-range single channel falls back to channel 0.
        start = 1'b1; single = 1'b1; sel_ch = 4'd15;
        step();
        start = 1'b0;
        chk("o_valid", 32'(ld_valid), 1);
        chk("o_addr",  32'(ld_addr),  0);
        chk("o_data",  32'(ld_data),  32'h59);
        step();
        chk("o_done",  32'(done),     1);
        chk("o_valid_off", 32'(ld_valid), 0);
        step();
        chk("o_idle_valid", 32'(ld_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
